logic_axi4_stream_packet_arbiter: RTL
=====================================

// Module: logic_axi4_stream_packet_arbiter
//
// PURPOSE
//  Round-robin, packet-aware arbiter for an N-input AXI4-Stream multiplexer datapath.
//  - Watches tvalid/tlast of each requester and the downstream tready.
//  - Issues a registered one-hot grant and encoded index that drive the mux select.
//  - Holds a grant for a whole packet, so packets are never interleaved on tx.
//
// PARAMETERS
//  INPUTS          4    number of requesters; legal range 2..32
//  USE_TLAST       1    1: grant held until tlast beat; 0: every beat is a packet
//  TIMEOUT_CYCLES  256  stall limit for the watchdog (LOGIC_AXI4_STREAM_ARBITER_TIMEOUT_EN only); >=1
//  localparam INDEX_WIDTH = (INPUTS > 1) ? $clog2(INPUTS) : 1
//
// PORTS
//  aclk         in   1            clock
//  areset_n     in   1            reset, asynchronous, active-low
//  rx_tvalid    in   INPUTS       tvalid of each requester
//  rx_tlast     in   INPUTS       tlast of each requester; ignored when USE_TLAST=0
//  tx_tready    in   1            downstream tready
//  grant        out  INPUTS       one-hot grant; all zero when idle
//  grant_index  out  INDEX_WIDTH  binary index of the granted requester
//  grant_valid  out  1            a grant is active (== |grant)
//  timeout      out  1            1-cycle pulse on forced release (macro only; otherwise tied 0)
//
// BEHAVIOUR
//  - Reset values: grant=0, grant_index=0, grant_valid=0, timeout=0.
//    Internal state: fsm=IDLE, rr_pointer=0, stall counter=0.
//  - Beat transfer: xfer = grant_valid && rx_tvalid[grant_index] && tx_tready.
//  - FSM IDLE:
//    - If any rx_tvalid is set, select the first set bit at or after rr_pointer, searching upward.
//    - Wrap from INPUTS-1 to 0.
//    - Register grant/grant_index, set grant_valid, go to LOCKED.
//    - Latency: request to grant is 1 cycle.
//  - FSM LOCKED:
//    - The grant is stable and ignores all other requesters.
//    - On xfer && (rx_tlast[grant_index] || !USE_TLAST):
//      - Clear grant and grant_valid next cycle.
//      - rr_pointer <= (grant_index == INPUTS-1) ? 0 : grant_index + 1.
//      - Go to IDLE.
//    - Exactly one idle cycle separates consecutive grants.
//  - rr_pointer changes only on release, never on grant.
//  - Fairness: a requester that holds tvalid is granted within INPUTS-1 packets of others.
//  - tx_tready=0 in LOCKED: hold state; no release, even if tlast is present.
//  - Granted tvalid drops mid-packet: keep the grant (AXI rule, no release without tlast).
//  - Simultaneous requests at reset exit: rr_pointer=0, so the lowest index wins.
//  - Single-beat packet (tlast on first beat): grant for the beat cycle, then IDLE.
//  - Reset mid-packet: return immediately to reset values. The packet is abandoned; no timeout pulse.
//  - tvalid from non-granted inputs never affects LOCKED state.
//
// CONFIGURATION
//  LOGIC_AXI4_STREAM_ARBITER_TIMEOUT_EN
//  - Defined:
//    - In LOCKED, count cycles with !xfer; clear the count on any xfer.
//    - When the count reaches TIMEOUT_CYCLES-1 and another cycle passes without xfer,
//      release the grant exactly as a tlast release and advance rr_pointer.
//    - Pulse timeout=1 for one cycle, aligned with grant_valid falling.
//  - Undefined: no counter is implemented, timeout is constant 0, and the grant is held indefinitely.
//
// TESTING
//  1. INPUTS=4, rx_tvalid=4'b1111 held, 2-beat packets, tx_tready=1
//     -> grant_index sequence 0,1,2,3,0 with one idle cycle between grants.
//  2. Grant on input 2, tx_tready=0 for 10 cycles with tlast present
//     -> grant stays 4'b0100; releases one cycle after tready returns.
//  3. USE_TLAST=0, rx_tvalid=4'b0101 -> grants alternate 0,2,0,2, one beat each.
//  4. Only input 3 requests after a release from input 3 (pointer wraps to 0)
//     -> grant_index=3 after one cycle, pointer wrap verified.
//  5. Macro on, TIMEOUT_CYCLES=8, granted input stalls with tvalid=0
//     -> after 8 stall cycles timeout pulses once, grant clears, next requester granted.
//  6. areset_n asserted mid-packet on input 1 -> all outputs 0 asynchronously;
//     after release, rx_tvalid=4'b0011 -> input 0 granted first.

Source files
------------

// File: rtl/logic_axi4_stream_packet_arbiter.sv
// Round-robin, packet-aware grant generator for an N-input AXI4-Stream mux.
// Optional stall watchdog enabled by defining LOGIC_AXI4_STREAM_ARBITER_TIMEOUT_EN.
module logic_axi4_stream_packet_arbiter #(
   parameter int INPUTS         = 4,
   parameter int USE_TLAST      = 1,
   parameter int TIMEOUT_CYCLES = 256,
   localparam int INDEX_WIDTH   = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
   input  logic                   aclk,
   input  logic                   areset_n,
   input  logic [INPUTS-1:0]      rx_tvalid,
   input  logic [INPUTS-1:0]      rx_tlast,
   input  logic                   tx_tready,
   output logic [INPUTS-1:0]      grant,
   output logic [INDEX_WIDTH-1:0] grant_index,
   output logic                   grant_valid,
   output logic                   timeout
);

   if (INPUTS < 2 || INPUTS > 32 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("logic_axi4_stream_packet_arbiter: illegal parameter value");
   end

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                 state_reg, state_next;
   logic [INPUTS-1:0]      grant_reg, grant_next;
   logic [INDEX_WIDTH-1:0] index_reg, index_next;
   logic                   valid_reg, valid_next;
   logic [INDEX_WIDTH-1:0] rr_pointer_reg, rr_pointer_next;

   logic                   any_request;
   logic [INDEX_WIDTH-1:0] pick_index;
   logic [INPUTS-1:0]      pick_onehot;
   logic                   xfer;
   logic                   last_beat;
   logic                   release_pkt;
   logic                   force_release;
   logic [INDEX_WIDTH-1:0] pointer_after;

   // First requester at or above rr_pointer, wrapping from INPUTS-1 to 0.
   always_comb begin
      int  cand;
      logic found;
      any_request = |rx_tvalid;
      pick_index  = '0;
      found       = 1'b0;
      for (int i = 0; i < INPUTS; i++) begin
         cand = int'(rr_pointer_reg) + i;
         if (cand >= INPUTS) begin
            cand = cand - INPUTS;
         end
         if (!found && rx_tvalid[cand]) begin
            found      = 1'b1;
            pick_index = INDEX_WIDTH'(cand);
         end
      end
   end

   for (genvar gi = 0; gi < INPUTS; gi++) begin : g_onehot
      assign pick_onehot[gi] = (pick_index == INDEX_WIDTH'(gi));
   end

   assign xfer          = valid_reg && rx_tvalid[index_reg] && tx_tready;
   assign last_beat     = (USE_TLAST == 0) || rx_tlast[index_reg];
   assign release_pkt   = (state_reg == LOCKED) && xfer && last_beat;
   assign pointer_after = (index_reg == INDEX_WIDTH'(INPUTS - 1)) ? '0 : index_reg + 1'b1;

   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      index_next      = index_reg;
      valid_next      = valid_reg;
      rr_pointer_next = rr_pointer_reg;
      case (state_reg)
         IDLE: begin
            if (any_request) begin
               grant_next = pick_onehot;
               index_next = pick_index;
               valid_next = 1'b1;
               state_next = LOCKED;
            end
         end
         LOCKED: begin
            // Other requesters are ignored until the packet ends or the watchdog fires.
            if (release_pkt || force_release) begin
               grant_next      = '0;
               index_next      = '0;
               valid_next      = 1'b0;
               rr_pointer_next = pointer_after;
               state_next      = IDLE;
            end
         end
         default: begin
            grant_next = '0;
            index_next = '0;
            valid_next = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state_reg      <= IDLE;
         grant_reg      <= '0;
         index_reg      <= '0;
         valid_reg      <= 1'b0;
         rr_pointer_reg <= '0;
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         index_reg      <= index_next;
         valid_reg      <= valid_next;
         rr_pointer_reg <= rr_pointer_next;
      end
   end

`ifdef LOGIC_AXI4_STREAM_ARBITER_TIMEOUT_EN
   localparam int STALL_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [STALL_WIDTH-1:0] stall_cnt_reg, stall_cnt_next;
   logic                   timeout_reg;

   assign force_release = (state_reg == LOCKED) && !xfer
                          && (stall_cnt_reg == STALL_WIDTH'(TIMEOUT_CYCLES - 1));

   always_comb begin
      stall_cnt_next = '0;
      if (state_reg == LOCKED && !xfer && !force_release) begin
         stall_cnt_next = stall_cnt_reg + 1'b1;
      end
   end

   // Pulse is registered so it lines up with grant_valid falling.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         stall_cnt_reg <= '0;
         timeout_reg   <= 1'b0;
      end else begin
         stall_cnt_reg <= stall_cnt_next;
         timeout_reg   <= force_release;
      end
   end

   assign timeout = timeout_reg;
`else
   assign force_release = 1'b0;
   assign timeout       = 1'b0;
`endif

   assign grant       = grant_reg;
   assign grant_index = index_reg;
   assign grant_valid = valid_reg;

endmodule
